// File: rtl/line_drawer.sv
// ---------------------------------------------------------------------------
// line_drawer
//
// Rasterises one straight line segment per request into a stream of pixel
// writes using integer Bresenham stepping (all eight octants). Endpoints are
// latched when start is accepted. One pixel is presented per handshake
// towards the back-buffer write port.
//
// Optional feature macro: LINE_DRAWER_CLIP_EN
//   defined   : pixels outside the visible area are not written. Each one
//               still takes one cycle, and stepping continues to (x2,y2).
//   undefined : every pixel is written. The framebuffer handles
//               out-of-range addresses.
//
// Ports
//   clk          in   single clock
//   rst          in   synchronous reset, active-high
//   x1, y1       in   start point (unsigned)
//   x2, y2       in   end point (unsigned)
//   start        in   request, sampled only while ready=1
//   ready        out  idle, can accept start
//   pixel_x/y    out  current pixel coordinate
//   pixel_write  out  pixel valid
//   pixel_ready  in   framebuffer accepts pixel this cycle
//
// States
//   S_IDLE | waiting for start, ready=1
//   S_DRAW | presenting / stepping pixels of the current line
// ---------------------------------------------------------------------------
module line_drawer #(
  parameter  int HOR_ACTIVE_PIXELS = 640,
  parameter  int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  input  logic               start,
  output logic               ready,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_write,
  input  logic               pixel_ready
);

  // Two guard bits: one for the sign, one so that e2 = 2*err never wraps.
  localparam int E_WIDTH = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

`ifdef LINE_DRAWER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [X_WIDTH:0]   X_LIMIT = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS);
  localparam logic [Y_WIDTH:0]   Y_LIMIT = (Y_WIDTH+1)'(VER_ACTIVE_PIXELS);
  localparam logic [X_WIDTH-1:0] X_ONE   = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] Y_ONE   = Y_WIDTH'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DRAW = 1'b1
  } state_t;

  state_t                     r_state;
  logic [X_WIDTH-1:0]         r_cx;
  logic [Y_WIDTH-1:0]         r_cy;
  logic [X_WIDTH-1:0]         r_x2;
  logic [Y_WIDTH-1:0]         r_y2;
  logic signed [E_WIDTH-1:0]  r_dx;
  logic signed [E_WIDTH-1:0]  r_dy;
  logic signed [E_WIDTH-1:0]  r_err;
  logic                       r_sx_neg;
  logic                       r_sy_neg;
  logic                       r_ready;
  logic                       r_pixel_write;

  logic [X_WIDTH-1:0]         w_dx_abs;
  logic [Y_WIDTH-1:0]         w_dy_abs;
  logic signed [E_WIDTH-1:0]  w_dx_start;
  logic signed [E_WIDTH-1:0]  w_dy_start;
  logic signed [E_WIDTH-1:0]  w_e2;
  logic signed [E_WIDTH-1:0]  w_err_next;
  logic                       w_step_x;
  logic                       w_step_y;
  logic                       w_step;
  logic                       w_at_end;
  logic [X_WIDTH-1:0]         w_nx;
  logic [Y_WIDTH-1:0]         w_ny;

  // Visible-area test; with clipping disabled every pixel is writable.
  function automatic logic f_visible(input logic [X_WIDTH-1:0] x,
                                     input logic [Y_WIDTH-1:0] y);
    return !CLIP_EN || (({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT));
  endfunction

  // Setup values for a new line, taken straight from the input ports.
  always_comb begin
    w_dx_abs   = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
    w_dy_abs   = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
    w_dx_start = $signed({{(E_WIDTH-X_WIDTH){1'b0}}, w_dx_abs});
    w_dy_start = -$signed({{(E_WIDTH-Y_WIDTH){1'b0}}, w_dy_abs});
  end

  // One Bresenham step. Both axis decisions use the pre-step err/e2.
  always_comb begin
    w_e2       = $signed({r_err[E_WIDTH-2:0], 1'b0});
    w_step_x   = (w_e2 >= r_dy);
    w_step_y   = (w_e2 <= r_dx);
    w_err_next = r_err;
    w_nx       = r_cx;
    w_ny       = r_cy;
    if (w_step_x) begin
      w_err_next = w_err_next + r_dy;
      w_nx       = r_sx_neg ? (r_cx - X_ONE) : (r_cx + X_ONE);
    end
    if (w_step_y) begin
      w_err_next = w_err_next + r_dx;
      w_ny       = r_sy_neg ? (r_cy - Y_ONE) : (r_cy + Y_ONE);
    end
  end

  // A written pixel advances on handshake; a clipped one advances at once.
  always_comb begin
    w_at_end = (r_cx == r_x2) && (r_cy == r_y2);
    w_step   = (r_state == S_DRAW) && (!r_pixel_write || pixel_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_pixel_write <= 1'b0;
      r_cx          <= '0;
      r_cy          <= '0;
      r_x2          <= '0;
      r_y2          <= '0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_err         <= '0;
      r_sx_neg      <= 1'b0;
      r_sy_neg      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cx          <= x1;
            r_cy          <= y1;
            r_x2          <= x2;
            r_y2          <= y2;
            r_dx          <= w_dx_start;
            r_dy          <= w_dy_start;
            r_err         <= w_dx_start + w_dy_start;
            r_sx_neg      <= (x2 < x1);
            r_sy_neg      <= (y2 < y1);
            r_ready       <= 1'b0;
            r_pixel_write <= f_visible(x1, y1);
            r_state       <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (w_step) begin
            if (w_at_end) begin
              r_state       <= S_IDLE;
              r_ready       <= 1'b1;
              r_pixel_write <= 1'b0;
            end else begin
              r_cx          <= w_nx;
              r_cy          <= w_ny;
              r_err         <= w_err_next;
              r_pixel_write <= f_visible(w_nx, w_ny);
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_ready       <= 1'b1;
          r_pixel_write <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign pixel_x     = r_cx;
  assign pixel_y     = r_cy;
  assign pixel_write = r_pixel_write;

endmodule

// File: tb/tb_line_drawer.sv
// ---------------------------------------------------------------------------
// tb_line_drawer
//
// Self-checking bench for line_drawer. Expected pixel lists come from a
// plain-integer Bresenham reference; expected completion cycles come from
// walking that list against the pixel_ready pattern applied to the DUT.
// Honours LINE_DRAWER_CLIP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_line_drawer;

  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int HOR = 640;
  localparam int VER = 480;

`ifdef LINE_DRAWER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XW-1:0] x1 = '0, x2 = '0;
  logic [YW-1:0] y1 = '0, y2 = '0;
  logic          start = 1'b0;
  logic          pixel_ready = 1'b1;
  logic          ready;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          pixel_write;

  line_drawer dut (
    .clk        (clk),
    .rst        (rst),
    .x1         (x1),
    .y1         (y1),
    .x2         (x2),
    .y2         (y2),
    .start      (start),
    .ready      (ready),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_write(pixel_write),
    .pixel_ready(pixel_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ex_q[$], ey_q[$];   // every pixel of the reference line
  int wx_q[$], wy_q[$];   // pixels expected to be written
  int gx_q[$], gy_q[$];   // pixels written by the DUT
  int g_ready;            // cycle in which the DUT showed ready again
  bit stall[8192];

  function automatic bit visible(input int x, input int y);
    return !CLIP || (x < HOR && y < VER);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model(input int ax1, input int ay1, input int ax2, input int ay2);
    int x, y, dx, dy, sx, sy, err, e2;
    ex_q.delete(); ey_q.delete(); wx_q.delete(); wy_q.delete();
    x = ax1; y = ay1;
    dx = iabs(ax2 - ax1); dy = -iabs(ay2 - ay1);
    sx = (ax2 >= ax1) ? 1 : -1;
    sy = (ay2 >= ay1) ? 1 : -1;
    err = dx + dy;
    forever begin
      ex_q.push_back(x); ey_q.push_back(y);
      if (visible(x, y)) begin
        wx_q.push_back(x); wy_q.push_back(y);
      end
      if (x == ax2 && y == ay2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // stall_mode: 0 none, 1 pixel_ready low in cycles 2..4, 2 random.
  // busy_cyc: cycle in which a stray start is driven (0 = never).
  task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                          input int stall_mode, input int busy_cyc, input string name);
    int  c, n, exp_ready, px, py;
    bit  hold;
    model(ax1, ay1, ax2, ay2);
    for (int i = 0; i < 8192; i++)
      stall[i] = (stall_mode == 1) ? (i >= 2 && i <= 4)
               : (stall_mode == 2) ? ($urandom_range(3) == 0) : 1'b0;
    exp_ready = 1;
    for (int i = 0; i < ex_q.size(); i++) begin
      if (visible(ex_q[i], ey_q[i]))
        while (stall[exp_ready]) exp_ready++;
      exp_ready++;
    end

    n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    gx_q.delete(); gy_q.delete();
    g_ready = -1;
    x1 = XW'(ax1); y1 = YW'(ay1); x2 = XW'(ax2); y2 = YW'(ay2);
    start = 1'b1; pixel_ready = 1'b1;
    @(posedge clk);
    hold = 1'b0; px = 0; py = 0;
    for (c = 1; c < 6000; c++) begin
      @(negedge clk);
      pixel_ready = !stall[c];
      start = (c == busy_cyc);
      x1 = XW'($urandom); y1 = YW'($urandom); x2 = XW'($urandom); y2 = YW'($urandom);
      if (hold) begin
        checks++;
        if (pixel_x !== XW'(px) || pixel_y !== YW'(py) || pixel_write !== 1'b1) begin
          errors++;
          $display("FAIL %s hold c%0d: got (%0d,%0d) w=%0b, want (%0d,%0d) w=1",
                   name, c, pixel_x, pixel_y, pixel_write, px, py);
        end
      end
      if (ready === 1'b1) begin
        start = 1'b0;
        g_ready = c;
        break;
      end
      hold = pixel_write && !pixel_ready;
      px = int'(pixel_x); py = int'(pixel_y);
      if (pixel_write && pixel_ready) begin
        gx_q.push_back(int'(pixel_x)); gy_q.push_back(int'(pixel_y));
      end
    end
    start = 1'b0; pixel_ready = 1'b1;

    checks++;
    if (g_ready < 0) begin
      errors++;
      $display("FAIL %s timeout: ready never returned, want cycle %0d", name, exp_ready);
    end
    checks++;
    if (gx_q.size() != wx_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d writes, want %0d", name, gx_q.size(), wx_q.size());
    end
    for (int i = 0; i < gx_q.size() && i < wx_q.size(); i++) begin
      checks++;
      if (gx_q[i] != wx_q[i] || gy_q[i] != wy_q[i]) begin
        errors++;
        $display("FAIL %s pixel %0d: got (%0d,%0d), want (%0d,%0d)",
                 name, i, gx_q[i], gy_q[i], wx_q[i], wy_q[i]);
      end
    end
    checks++;
    if (g_ready != exp_ready) begin
      errors++;
      $display("FAIL %s ready cycle: got %0d, want %0d", name, g_ready, exp_ready);
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if (pixel_write !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL %s idle: got write=%0b ready=%0b, want write=0 ready=1",
                 name, pixel_write, ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || pixel_write !== 1'b0 || pixel_x !== '0 || pixel_y !== '0) begin
      errors++;
      $display("FAIL reset: got ready=%0b write=%0b xy=(%0d,%0d), want 1 0 (0,0)",
               ready, pixel_write, pixel_x, pixel_y);
    end
    rst = 1'b0;
    check_idle("reset", 1);
  endtask

  task automatic test_horizontal();
    int hx[4] = '{0, 1, 2, 3};
    run_line(0, 0, 3, 0, 0, 0, "horizontal");
    for (int i = 0; i < 4 && i < gx_q.size(); i++) begin
      checks++;
      if (gx_q[i] != hx[i] || gy_q[i] != 0) begin
        errors++;
        $display("FAIL horizontal const %0d: got (%0d,%0d), want (%0d,0)", i, gx_q[i], gy_q[i], hx[i]);
      end
    end
    checks++;
    if (g_ready != 5) begin
      errors++;
      $display("FAIL horizontal ready: got %0d, want 5", g_ready);
    end
  endtask

  task automatic test_single_point();
    run_line(10, 20, 10, 20, 0, 0, "single");
    checks++;
    if (gx_q.size() != 1 || g_ready != 2) begin
      errors++;
      $display("FAIL single: got %0d writes ready %0d, want 1 writes ready 2", gx_q.size(), g_ready);
    end
  endtask

  task automatic test_steep_reversed();
    int sx[6] = '{5, 5, 4, 4, 3, 3};
    int sy[6] = '{7, 6, 5, 4, 3, 2};
    run_line(5, 7, 3, 2, 0, 0, "steep");
    for (int i = 0; i < 6 && i < gx_q.size(); i++) begin
      checks++;
      if (gx_q[i] != sx[i] || gy_q[i] != sy[i]) begin
        errors++;
        $display("FAIL steep const %0d: got (%0d,%0d), want (%0d,%0d)", i, gx_q[i], gy_q[i], sx[i], sy[i]);
      end
    end
  endtask

  task automatic test_octants();
    int a, b, dx, dy;
    for (int o = 0; o < 8; o++) begin
      a = $urandom_range(200, 1);
      b = $urandom_range(a);
      dx = o[2] ? b : a;
      dy = o[2] ? a : b;
      if (o[0]) dx = -dx;
      if (o[1]) dy = -dy;
      run_line(300, 240, 300 + dx, 240 + dy, 2, 0, $sformatf("octant%0d", o));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_line($urandom_range(1023), $urandom_range(511), $urandom_range(1023),
               $urandom_range(511), 2, 0, $sformatf("random%0d", i));
  endtask

  task automatic test_back_pressure();
    run_line(0, 0, 2, 2, 1, 0, "backpressure");
    checks++;
    if (g_ready != 7) begin
      errors++;
      $display("FAIL backpressure ready: got %0d, want 7", g_ready);
    end
  endtask

  task automatic test_clipping();
    run_line(636, 0, 643, 0, 0, 0, "clip");
    checks++;
    if (gx_q.size() != (CLIP ? 4 : 8) || g_ready != 9) begin
      errors++;
      $display("FAIL clip: got %0d writes ready %0d, want %0d writes ready 9",
               gx_q.size(), g_ready, CLIP ? 4 : 8);
    end
  endtask

  task automatic test_back_to_back();
    run_line(20, 30, 25, 33, 0, 0, "b2b_a");
    run_line(25, 33, 18, 40, 0, 0, "b2b_b");
    run_line(7, 7, 7, 7, 0, 0, "b2b_c");
  endtask

  task automatic test_busy_start();
    run_line(0, 0, 5, 0, 0, 2, "busy");
    check_idle("busy_after", 3);
  endtask

  task automatic test_reset_mid_line();
    @(negedge clk);
    x1 = '0; y1 = '0; x2 = XW'(9); y2 = '0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (pixel_write !== 1'b1 || pixel_x !== XW'(c - 1)) begin
        errors++;
        $display("FAIL midreset pre c%0d: got write=%0b x=%0d, want 1 %0d", c, pixel_write, pixel_x, c - 1);
      end
      if (c == 3) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pixel_write !== 1'b0 || ready !== 1'b1 || pixel_x !== '0) begin
        errors++;
        $display("FAIL midreset post %0d: got write=%0b ready=%0b x=%0d, want 0 1 0",
                 i, pixel_write, ready, pixel_x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_single_point();
    test_steep_reversed();
    test_back_pressure();
    test_clipping();
    test_octants();
    test_random();
    test_back_to_back();
    test_busy_start();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
